// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller and the CPU load unit:
// access-size encodings, controller FSM states, and lane select/extend helpers.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Select the addressed lane of a word, right-align it and extend it.
    function automatic logic [31:0] lane_extract(
        input logic [31:0] w,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        sgn
    );
        logic [31:0] sh;
        sh = w >> {off, 3'b000};
        case (size)
            SZ_BYTE: lane_extract = {{24{sgn & sh[7]}}, sh[7:0]};
            SZ_HALF: lane_extract = {{16{sgn & sh[15]}}, sh[15:0]};
            default: lane_extract = w;
        endcase
    endfunction

    // Byte enables for a store of the given size at byte offset off.
    function automatic logic [3:0] lane_be(
        input logic [1:0] size,
        input logic [1:0] off
    );
        case (size)
            SZ_BYTE: lane_be = 4'b0001 << off;
            SZ_HALF: lane_be = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lane_be = 4'b1111;
            default: lane_be = 4'b0000;
        endcase
    endfunction

    // Replicate right-aligned store data across every lane it could target.
    function automatic logic [31:0] lane_rep(
        input logic [1:0]  size,
        input logic [31:0] wdata
    );
        case (size)
            SZ_BYTE: lane_rep = {4{wdata[7:0]}};
            SZ_HALF: lane_rep = {2{wdata[15:0]}};
            default: lane_rep = wdata;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_ram.sv
// Byte-enabled, synchronous-read, single-port word RAM (read-before-write).
// Ports: clk_i, we_i, be_i[3:0], addr_i (word index), wdata_i, rdata_o.
module dmem_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] INIT_WORD0  = 32'h0000_0138,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    // Power-up image only; reset never touches the array.
    logic [31:0] mem_q [DEPTH_WORDS] = '{0: INIT_WORD0, default: 32'h0};

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (we_i && be_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: decodes RAM vs. MMIO (seg7/LED), checks alignment,
// sequences IDLE->RD->RESP, and holds the response until resp_ready.
// Ports: clk, rst, req_* (request handshake), resp_* (response), seg7, led_data.
import dmem_ctrl_pkg::*;

module dmem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] SEG_ADDR    = 32'h0000_0FFC,
    parameter logic [31:0] LED_ADDR    = 32'h0000_0FF8,
    parameter logic [31:0] INIT_WORD0  = 32'h0000_0138
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] seg7,
    output logic [31:0] led_data
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_e      state_q;
    logic        resp_valid_q, resp_err_q;
    logic [31:0] resp_rdata_q, seg7_q, led_q;
    logic [1:0]  off_q, size_q;
    logic        signed_q, rd_seg_q, rd_led_q;
    logic        pend_seg_q, pend_led_q;
    logic [31:0] pend_data_q;

    logic [29:0] widx;
    logic        is_seg, is_led, is_mmio, in_ram, misal, req_err, accept;
    logic [3:0]  be;
    logic [31:0] wrep, mmio_old, mmio_d, ram_rdata, rd_src;
    logic        ram_we;

    assign widx    = req_addr[31:2];
    assign is_seg  = widx == SEG_ADDR[31:2];
    assign is_led  = widx == LED_ADDR[31:2];
    assign is_mmio = is_seg | is_led;
    assign in_ram  = ({2'b00, widx} < 32'(DEPTH_WORDS)) && !is_mmio;
    assign misal   = (req_size == SZ_HALF && req_addr[0]) ||
                     (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
    assign req_err = (req_size == SZ_ILL) | misal | !(is_mmio | in_ram);
    assign accept  = req_valid && req_ready;

    assign be       = lane_be(req_size, req_addr[1:0]);
    assign wrep     = lane_rep(req_size, req_wdata);
    assign mmio_old = is_seg ? seg7_q : led_q;
    assign mmio_d   = (mmio_old & ~{{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}}) |
                      (wrep & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}});

    // RAM writes commit on the accept edge unless reset is also high.
    assign ram_we = accept && req_we && !req_err && in_ram && !rst;

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_WORD0  (INIT_WORD0)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .be_i    (be),
        .addr_i  (req_addr[AW+1:2]),
        .wdata_i (wrep),
        .rdata_o (ram_rdata)
    );

    assign rd_src = rd_seg_q ? seg7_q : (rd_led_q ? led_q : ram_rdata);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            seg7_q       <= 32'h0;
            led_q        <= 32'h0;
            pend_seg_q   <= 1'b0;
            pend_led_q   <= 1'b0;
        end else begin
            // MMIO registers change one edge after the store is accepted.
            if (pend_seg_q) seg7_q <= pend_data_q;
            if (pend_led_q) led_q  <= pend_data_q;
            pend_seg_q <= 1'b0;
            pend_led_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        off_q    <= req_addr[1:0];
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        rd_seg_q <= is_seg;
                        rd_led_q <= is_led;
                        if (req_err || req_we) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= req_err;
                            resp_rdata_q <= 32'h0;
                            if (!req_err) begin
                                pend_seg_q  <= is_seg;
                                pend_led_q  <= is_led;
                                pend_data_q <= mmio_d;
                            end
                        end else begin
                            state_q <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    state_q      <= ST_RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= lane_extract(rd_src, off_q, size_q, signed_q);
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= 32'h0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = state_q == ST_IDLE;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign seg7       = seg7_q;
    assign led_data   = led_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed requests push expected responses,
// a negedge monitor pops and compares on every accepted response.
module tb_dmem_ctrl;

    localparam logic [31:0] SEG = 32'h0000_0FFC;
    localparam logic [31:0] LED = 32'h0000_0FF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
    logic        resp_ready = 1'b1;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [1:0]  req_size = 2'b10;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata, seg7, led_data;

    int total = 0;
    int bad = 0;
    logic [32:0] sbq[$];

    always #5 clk = ~clk;

    dmem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .req_signed (req_signed),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .seg7       (seg7),
        .led_data   (led_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [32:0] e;
        if (resp_valid === 1'b1 && resp_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_unexpected: got %08h want none", resp_rdata);
            end else begin
                e = sbq.pop_front();
                chk("resp_rdata", resp_rdata, e[31:0]);
                chk("resp_err", {31'b0, resp_err}, {31'b0, e[32]});
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 20);
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got req_ready=0 want 1");
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic sg);
        req_valid = 1'b1;
        req_we = we;
        req_addr = a;
        req_wdata = wd;
        req_size = sz;
        req_signed = sg;
    endtask

    // One request; exp_lat>0 checks accept-to-valid latency, stall holds resp_ready low.
    task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic sg,
                        input logic [31:0] exp_d, input logic exp_e,
                        input int exp_lat, input int stall);
        int lat;
        @(negedge clk);
        if (stall > 0) resp_ready = 1'b0;
        drive(we, a, wd, sz, sg);
        sbq.push_back({exp_e, exp_d});
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        if (exp_lat > 0) chk("latency", lat, exp_lat);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", {31'b0, resp_valid}, 32'h1);
            chk("stall_rdata", resp_rdata, exp_d);
            chk("stall_ready", {31'b0, req_ready}, 32'h0);
        end
        resp_ready = 1'b1;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_seg7", seg7, 32'h0);
        chk("rst_led", led_data, 32'h0);

        xact(0, 32'h0, 0, 2'b10, 0, 32'h0000_0138, 0, 2, 0);

        xact(1, 32'h10, 32'h1234_5678, 2'b10, 0, 32'h0, 0, 1, 0);
        xact(0, 32'h10, 0, 2'b10, 0, 32'h1234_5678, 0, 2, 0);
        xact(0, 32'h13, 0, 2'b00, 1, 32'h0000_0012, 0, 0, 0);
        xact(0, 32'h12, 0, 2'b01, 0, 32'h0000_1234, 0, 0, 0);

        xact(1, 32'h20, 32'hA1B2_C3D4, 2'b10, 0, 32'h0, 0, 0, 0);
        xact(1, 32'h21, 32'h0000_0080, 2'b00, 0, 32'h0, 0, 1, 0);
        xact(0, 32'h21, 0, 2'b00, 1, 32'hFFFF_FF80, 0, 0, 0);
        xact(0, 32'h21, 0, 2'b00, 0, 32'h0000_0080, 0, 0, 0);
        xact(0, 32'h20, 0, 2'b10, 0, 32'hA1B2_80D4, 0, 0, 0);
        xact(0, 32'h22, 0, 2'b01, 1, 32'hFFFF_A1B2, 0, 0, 0);
        xact(1, 32'h26, 32'h0000_BEEF, 2'b01, 0, 32'h0, 0, 0, 0);
        xact(0, 32'h24, 0, 2'b10, 0, 32'hBEEF_0000, 0, 0, 0);

        xact(0, 32'h6, 0, 2'b10, 0, 32'h0, 1, 1, 0);
        xact(0, 32'h3, 0, 2'b01, 0, 32'h0, 1, 1, 0);
        xact(0, 32'h10, 0, 2'b11, 0, 32'h0, 1, 1, 0);
        xact(0, 32'h1000, 0, 2'b10, 0, 32'h0, 1, 1, 0);
        xact(1, 32'h12, 32'hDEAD_BEEF, 2'b10, 0, 32'h0, 1, 1, 0);
        xact(1, 32'h20, 32'hDEAD_BEEF, 2'b11, 0, 32'h0, 1, 1, 0);
        xact(1, 32'h1004, 32'hDEAD_BEEF, 2'b10, 0, 32'h0, 1, 1, 0);
        xact(0, 32'h10, 0, 2'b10, 0, 32'h1234_5678, 0, 0, 0);
        xact(0, 32'h20, 0, 2'b10, 0, 32'hA1B2_80D4, 0, 0, 0);

        @(negedge clk);
        drive(1, SEG, 32'h0000_ABCD, 2'b10, 0);
        sbq.push_back({1'b0, 32'h0});
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("seg7_at_commit", seg7, 32'h0);
        @(posedge clk);
        #1 chk("seg7_after", seg7, 32'h0000_ABCD);
        wait_idle();
        xact(0, SEG, 0, 2'b10, 0, 32'h0000_ABCD, 0, 2, 0);
        xact(0, SEG + 1, 0, 2'b00, 0, 32'h0000_00AB, 0, 0, 0);
        xact(1, LED + 2, 32'h0000_5A5A, 2'b01, 0, 32'h0, 0, 0, 0);
        chk("led_after", led_data, 32'h5A5A_0000);
        xact(0, LED, 0, 2'b10, 0, 32'h5A5A_0000, 0, 0, 0);

        xact(0, 32'h10, 0, 2'b10, 0, 32'h1234_5678, 0, 2, 5);

        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst2_seg7", seg7, 32'h0);
        chk("rst2_led", led_data, 32'h0);
        xact(0, 32'h10, 0, 2'b10, 0, 32'h1234_5678, 0, 0, 0);

        @(negedge clk);
        drive(0, 32'h10, 0, 2'b10, 0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_rd_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_rd_ready", {31'b0, req_ready}, 32'h1);

        @(negedge clk);
        resp_ready = 1'b0;
        drive(1, 32'h30, 32'h55, 2'b10, 0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("resp_pre_rst", {31'b0, resp_valid}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        resp_ready = 1'b1;
        chk("rst_resp_valid2", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_ready2", {31'b0, req_ready}, 32'h1);

        @(negedge clk);
        drive(1, 32'h34, 32'h99, 2'b10, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b0;
        xact(0, 32'h34, 0, 2'b10, 0, 32'h0, 0, 0, 0);
        xact(0, 32'h30, 0, 2'b10, 0, 32'h0000_0055, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sbq.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, RAM depth in 32-bit words, power of two, 16..65536.
REQ-002 Parameter SEG_ADDR, default 32'h0000_0FFC, byte address of the seven-segment register.
REQ-003 Parameter LED_ADDR, default 32'h0000_0FF8, byte address of the LED register.
REQ-004 Parameter INIT_WORD0, default 32'h0000_0138, power-up content of RAM word 0.
REQ-005 clk  in  1  sole clock, all state on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  controller can accept a request.
REQ-009 req_we  in  1  1 = store, 0 = load.
REQ-010 req_addr  in  32  byte address.
REQ-011 req_wdata  in  32  store data, right-aligned.
REQ-012 req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-013 req_signed  in  1  sign-extend sub-word loads.
REQ-014 resp_valid  out  1  response present.
REQ-015 resp_ready  in  1  consumer accepts the response.
REQ-016 resp_rdata  out  32  load data, right-aligned and extended; 0 for stores and errors.
REQ-017 resp_err  out  1  request was misaligned, out of range, or used an illegal size.
REQ-018 seg7  out  32  seven-segment register contents.
REQ-019 led_data  out  32  LED register contents.

Function
REQ-020 FSM states: IDLE, RD, RESP.
- req_ready = 1 only in IDLE.
- A request is accepted on a rising edge where req_valid && req_ready.
REQ-021 Address decode is done on accept:
- MMIO when req_addr equals SEG_ADDR or LED_ADDR (word-compared, addr[1:0] ignored).
- RAM when req_addr[31:2] < DEPTH_WORDS and the address is not MMIO.
- MMIO has priority over RAM.
- Any other address is out of range, which is an error.
REQ-022 Misalignment is an error: half with addr[0]=1, or word with addr[1:0]!=0.
REQ-023 An error request is accepted, does not modify any state, and goes IDLE->RESP with resp_err=1 and resp_rdata=0.
REQ-024 Store, little-endian lanes:
- byte writes lane addr[1:0];
- half writes lanes {addr[1],0}+1..{addr[1],0};
- word writes all lanes;
- the write commits on the accept edge;
- FSM goes IDLE->RESP with resp_err=0, resp_rdata=0.
REQ-025 Load:
- The RAM is synchronous-read, addressed at accept.
- FSM goes IDLE->RD->RESP.
- RD latches the selected lane, shifted right and zero- or sign-extended per req_signed (latched at accept).
REQ-026 MMIO load returns the register value through the same RD path and latency, with sub-word lanes applied identically.
REQ-027 Latency from accept edge to resp_valid high: store 1 cycle, load 2 cycles, error 1 cycle.
REQ-028 In RESP, resp_valid=1 and resp_rdata/resp_err are held stable until a rising edge with resp_ready=1, then the FSM returns to IDLE. No back-to-back accept occurs in that same cycle.
REQ-029 seg7 and led_data are continuously driven from their registers, and update on the edge following the store commit edge.
REQ-030 A load immediately after a store to the same address returns the new data.

Reset
REQ-031 rst forces state IDLE, resp_valid=0, resp_err=0, resp_rdata=0, seg7=0, led_data=0 on the next rising edge. This overrides any in-flight request.
REQ-032 RAM contents are not cleared by rst. Word 0 = INIT_WORD0 at power-up only.
REQ-033 A store whose accept edge coincides with rst high does not commit.

Structure
REQ-034 A shared package holds the req_size encodings, the FSM state enum, and a lane-extract/extend function reused by the CPU load unit.
REQ-035 One sub-module, dmem_ram, holds the byte-enabled synchronous-read single-port RAM (parameters DEPTH_WORDS, INIT_WORD0); decode, FSM and MMIO stay in dmem_ctrl.

Verification
REQ-036 Store word 0x12345678 @0x10, load byte signed @0x13 -> resp_rdata 0x00000012; load half unsigned @0x12 -> 0x00001234.
REQ-037 Store byte 0x80 @0x21, load byte signed @0x21 -> 0xFFFFFF80; load word @0x20 -> only lane 1 changed, other lanes keep their prior contents.
REQ-038 Load word @0x6, half @0x3, size 11, and word @(DEPTH_WORDS*4) -> each gives resp_err=1, resp_rdata=0, and RAM unchanged.
REQ-039 Store word 0x0000ABCD @SEG_ADDR -> seg7=0x0000ABCD one cycle after commit; load @SEG_ADDR returns it; rst -> seg7=0, RAM word 0x10 unchanged.
REQ-040 Hold resp_ready=0 for 5 cycles on a load -> resp_valid and resp_rdata stable, req_ready=0 throughout; measured latencies exactly 2 (load) and 1 (store).
REQ-041 Assert rst in RD and in RESP -> next cycle IDLE, resp_valid=0, req_ready=1.
